// File: rtl/arbitro_interrupcao.sv
// Multi-source interrupt arbiter: edge-captured pending requests, software mask,
// fixed priority (bit 0 highest), single in-service interrupt closed by eret.
module arbitro_interrupcao #(
    parameter int unsigned N_IRQ = 4,
    parameter int unsigned PC_W  = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_in,
    input  logic [PC_W-1:0]  pc,
    input  logic             ack,
    input  logic             eret,
    output logic             intr,
    output logic [31:0]      cause,
    output logic [31:0]      pcBckp,
    output logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERV
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] clr;
    logic [4:0]       sel;
    logic             any;
    logic             take;

    assign eligible = pending & mask;
    assign any      = |eligible;

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        sel = '0;
        for (int unsigned k = N_IRQ; k > 0; k--) begin
            if (eligible[k-1]) sel = 5'(k - 1);
        end
    end

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            IDLE: if (any) state_nx = REQ;
            REQ: begin
                if (ack && any) begin
                    take     = 1'b1;
                    state_nx = SERV;
                end else if (!any) begin
                    state_nx = IDLE;
                end
            end
            SERV: if (eret) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        clr = '0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            clr[k] = take && (sel == 5'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            intr    <= 1'b0;
            cause   <= '0;
            pcBckp  <= '0;
            pending <= '0;
            mask    <= '1;
            irq_q   <= '0;
        end else begin
            state   <= state_nx;
            intr    <= (state_nx == REQ);
            irq_q   <= irq;
            // A new rise in the acknowledge cycle keeps the bit pending.
            pending <= (pending & ~clr) | (irq & ~irq_q);
            if (mask_we) mask <= mask_in;
            if (take) begin
                cause  <= 32'(sel) + 32'd1;
                pcBckp <= 32'(pc);
            end else if (state == SERV && eret) begin
                cause  <= '0;
            end
        end
    end

endmodule
